// File: rtl/aes_round_ctrl_pkg.sv
// Shared AES-128 constants and the round controller state encoding,
// used by the controller, key expansion and round datapath.
package aes_round_ctrl_pkg;

  localparam int AES_NR = 10;
  localparam int AES_RW = 4;

  typedef enum logic [2:0] {
    IDLE,
    KEY_SETTLE,
    ARK0,
    KEY_STEP,
    EXEC,
    DONE
  } ctrl_state_t;

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Key, plaintext and ciphertext handshakes between the rx logic / consumer
// (master side) and the AES round controller (slave side).
interface aes_round_ctrl_if;

  logic key_valid;
  logic key_ready;
  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;

  modport master (
    output key_valid,
    output in_valid,
    output out_ready,
    input  key_ready,
    input  in_ready,
    input  out_valid
  );

  modport slave (
    input  key_valid,
    input  in_valid,
    input  out_ready,
    output key_ready,
    output in_ready,
    output out_valid
  );

endinterface

// File: rtl/aes_round_ctrl.sv
// AES-128 encrypt sequencer: loads the key, then walks each block through
// ARK0 and NR rounds, alternating key-step and execute cycles.
module aes_round_ctrl
  import aes_round_ctrl_pkg::*;
#(
  parameter int NR = AES_NR,
  parameter int RW = AES_RW
) (
  input  logic            clk,
  input  logic            n_rst,
  aes_round_ctrl_if.slave hs,
  output logic            key_load_o,
  output logic [RW-1:0]   cur_round_o,
  output logic            data_load_o,
  output logic            ark0_en_o,
  output logic            round_en_o,
  output logic            final_round_o,
  output logic            busy_o
);

  ctrl_state_t   state_q, state_d;
  logic [RW-1:0] round_q, round_d;
  logic          key_loaded_q, key_loaded_d;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      round_q      <= '0;
      key_loaded_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      round_q      <= round_d;
      key_loaded_q <= key_loaded_d;
    end
  end

  // Key requests take priority over a pending block in IDLE; the block waits.
  always_comb begin
    state_d       = state_q;
    round_d       = round_q;
    key_loaded_d  = key_loaded_q;
    hs.key_ready  = 1'b0;
    hs.in_ready   = 1'b0;
    hs.out_valid  = 1'b0;
    key_load_o    = 1'b0;
    data_load_o   = 1'b0;
    ark0_en_o     = 1'b0;
    round_en_o    = 1'b0;
    final_round_o = 1'b0;

    unique case (state_q)
      IDLE: begin
        hs.key_ready = 1'b1;
        hs.in_ready  = key_loaded_q;
        round_d      = '0;
        if (hs.key_valid) begin
          key_load_o = 1'b1;
          state_d    = KEY_SETTLE;
        end else if (hs.in_valid && key_loaded_q) begin
          data_load_o = 1'b1;
          state_d     = ARK0;
        end
      end
      KEY_SETTLE: begin
        key_loaded_d = 1'b1;
        state_d      = IDLE;
      end
      ARK0: begin
        ark0_en_o = 1'b1;
        round_d   = RW'(1);
        state_d   = KEY_STEP;
      end
      KEY_STEP: begin
        state_d = EXEC;
      end
      EXEC: begin
        round_en_o = 1'b1;
        if (round_q == RW'(NR)) begin
          final_round_o = 1'b1;
          state_d       = DONE;
        end else begin
          round_d = round_q + RW'(1);
          state_d = KEY_STEP;
        end
      end
      DONE: begin
        hs.out_valid = 1'b1;
        if (hs.out_ready) begin
          round_d = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        round_d = '0;
      end
    endcase
  end

  assign cur_round_o = round_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl: directed key/block sequence, then
// randomized handshakes against a cycle-count reference model.
module tb_aes_round_ctrl;
  import aes_round_ctrl_pkg::*;

  localparam int NR = AES_NR;
  localparam int RW = AES_RW;
  localparam int DONE_CYC = 2 * NR + 2;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          key_load, data_load, ark0_en, round_en, final_round, busy;
  logic [RW-1:0] cur_round;

  int testCount = 0;
  int failCount = 0;

  // Reference model: mode 0 idle, 1 key settle, 2 block; mCyc counts cycles since accept
  bit mLoaded;
  int mMode;
  int mCyc;
  bit lastOutValid;

  always #5 clk = ~clk;

  aes_round_ctrl_if hs();

  aes_round_ctrl #(.NR(NR), .RW(RW)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .hs           (hs),
    .key_load_o   (key_load),
    .cur_round_o  (cur_round),
    .data_load_o  (data_load),
    .ark0_en_o    (ark0_en),
    .round_en_o   (round_en),
    .final_round_o(final_round),
    .busy_o       (busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Packed as {key_ready,in_ready,out_valid,key_load,data_load,ark0,round_en,final,busy,cur_round}
  function automatic logic [31:0] expWord(input bit kv, input bit iv);
    bit kr = 0, ir = 0, ov = 0, kl = 0, dl = 0, a0 = 0, re = 0, fr = 0, by = 0;
    int cr = 0;
    case (mMode)
      0: begin
        kr = 1;
        ir = mLoaded;
        kl = kv;
        dl = !kv && iv && mLoaded;
      end
      1: by = 1;
      default: begin
        by = 1;
        if (mCyc == 1) a0 = 1;
        else cr = (mCyc / 2 > NR) ? NR : mCyc / 2;
        re = (mCyc >= 3) && (mCyc <= 2 * NR + 1) && (mCyc % 2 == 1);
        fr = re && (mCyc == 2 * NR + 1);
        ov = (mCyc >= DONE_CYC);
      end
    endcase
    return {19'b0, kr, ir, ov, kl, dl, a0, re, fr, by, RW'(cr)};
  endfunction

  function automatic logic [31:0] obsWord();
    return {19'b0, hs.key_ready, hs.in_ready, hs.out_valid, key_load, data_load,
            ark0_en, round_en, final_round, busy, cur_round};
  endfunction

  task automatic applyStimulus(input string tag, input bit kv, input bit iv, input bit ordy);
    @(negedge clk);
    hs.key_valid = kv;
    hs.in_valid  = iv;
    hs.out_ready = ordy;
    #1;
    checkOutput(tag, obsWord(), expWord(kv, iv));
    lastOutValid = hs.out_valid;
    @(posedge clk);
    case (mMode)
      0: begin
        if (kv) mMode = 1;
        else if (iv && mLoaded) begin
          mMode = 2;
          mCyc  = 1;
        end
      end
      1: begin
        mLoaded = 1;
        mMode   = 0;
      end
      default: begin
        if (mCyc >= DONE_CYC) begin
          if (ordy) mMode = 0;
        end else mCyc++;
      end
    endcase
  endtask

  task automatic doReset(input string tag);
    @(negedge clk);
    hs.key_valid = 1'b0;
    hs.in_valid  = 1'b0;
    hs.out_ready = 1'b0;
    #2 n_rst = 1'b0;
    mLoaded = 0;
    mMode   = 0;
    mCyc    = 0;
    #1;
    checkOutput(tag, obsWord(), expWord(0, 0));
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  initial begin
    int  latency;
    int  holdCount;
    bit  resetDone;
    bit  kv, iv, ordy;

    n_rst        = 1'b0;
    hs.key_valid = 1'b0;
    hs.in_valid  = 1'b0;
    hs.out_ready = 1'b0;
    mLoaded = 0;
    mMode   = 0;
    mCyc    = 0;
    lastOutValid = 0;
    resetDone = 0;

    doReset("reset");
    applyStimulus("no_key_block", 0, 1, 0);
    applyStimulus("key_wins", 1, 1, 0);
    applyStimulus("key_settle", 0, 1, 0);
    applyStimulus("accept", 0, 1, 0);

    // Walk one block, holding out_ready low for the first five DONE cycles
    latency   = 0;
    holdCount = 0;
    for (int i = 1; i <= 40; i++) begin
      applyStimulus("block", 0, 0, holdCount >= 5);
      if (lastOutValid) begin
        if (latency == 0) latency = i;
        holdCount++;
      end
      if (mMode == 0) break;
    end
    checkOutput("latency", latency, DONE_CYC);
    checkOutput("hold_cycles", holdCount, 6);

    for (int n = 0; n < 2500; n++) begin
      kv   = ($urandom_range(0, 15) == 0);
      iv   = $urandom_range(0, 1);
      ordy = ($urandom_range(0, 2) == 0);
      if (!resetDone && n > 300 && mMode == 2 && mCyc == 11) begin
        doReset("midblock_reset");
        resetDone = 1;
        applyStimulus("post_reset_inval", 0, 1, 0);
      end else begin
        applyStimulus("random", kv, iv, ordy);
      end
    end
    checkOutput("midblock_reset_hit", 32'(resetDone), 32'd1);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
